// File: rtl/vga_timing_decoder_if.sv
// ---------------------------------------------------------------------------
// vga_timing_decoder_if
// Groups the raw VGA link wires (hsync, vsync, packed {r,g,b}) so the
// display path and the timing decoder can be connected as one bundle.
//   hs   : horizontal sync, polarity chosen by the consumer
//   vs   : vertical sync, polarity chosen by the consumer
//   rgb  : pixel colour {r,g,b}, COLOR_W bits per channel
// Modports:
//   master : the VGA source drives the link
//   slave  : the VGA sink samples the link
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface vga_timing_decoder_if #(
    parameter int COLOR_W = 4
);
    logic                   hs;
    logic                   vs;
    logic [3*COLOR_W-1:0]   rgb;

    modport master (output hs, output vs, output rgb);
    modport slave  (input  hs, input  vs, input  rgb);
endinterface

// File: rtl/vga_timing_decoder.sv
// ---------------------------------------------------------------------------
// vga_timing_decoder
// Sink end of the board VGA link. Registers the incoming sync/colour
// samples, recovers pixel coordinates from the sync edges, checks line and
// frame lengths against the configured mode and reports lock and frame
// starts. Every output lags the input sample it describes by two clocks.
// Ports:
//   clk_i        : pixel clock
//   rst_i        : asynchronous reset, active-low
//   vga_i        : VGA link (hs, vs, rgb), slave side
//   pixel_x_o    : recovered x, 0 outside the visible window
//   pixel_y_o    : recovered y, 0 outside the visible window
//   visible_o    : sample lies inside the visible window
//   rgb_o        : registered colour, 0 outside the visible window
//   new_frame_o  : one-cycle pulse on each vsync assertion edge
//   locked_o     : timing locked
//   timing_err_o : one-cycle pulse on any timing violation
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module vga_timing_decoder #(
    parameter int H_TOTAL       = 800,
    parameter int V_TOTAL       = 525,
    parameter int H_START       = 144,
    parameter int V_START       = 35,
    parameter int H_VISIBLE     = 640,
    parameter int V_VISIBLE     = 480,
    parameter int HS_ACTIVE_LOW = 1,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int LOCK_FRAMES   = 2,
    parameter int X_POS_W       = 10,
    parameter int Y_POS_W       = 10,
    parameter int COLOR_W       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    vga_timing_decoder_if.slave     vga_i,
    output logic [X_POS_W-1:0]      pixel_x_o,
    output logic [Y_POS_W-1:0]      pixel_y_o,
    output logic                    visible_o,
    output logic [3*COLOR_W-1:0]    rgb_o,
    output logic                    new_frame_o,
    output logic                    locked_o,
    output logic                    timing_err_o
);

    localparam logic        HS_ON  = (HS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic        VS_ON  = (VS_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [11:0] H_MAX  = 12'hFFF;
    localparam logic [10:0] V_MAX  = 11'h7FF;
    localparam logic [11:0] H_LO   = 12'(H_START);
    localparam logic [11:0] H_HI   = 12'(H_START + H_VISIBLE);
    localparam logic [10:0] V_LO   = 11'(V_START);
    localparam logic [10:0] V_HI   = 11'(V_START + V_VISIBLE);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [10:0] V_LEN  = 11'(V_TOTAL);
    localparam logic [7:0]  GOOD_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t                 state_q;
    logic [7:0]             goodCnt_q;
    logic                   frameBad_q;
    logic                   locked_q;

    logic                   hs1_q, hs2_q, vs1_q, vs2_q;
    logic [3*COLOR_W-1:0]   rgb1_q;
    logic [11:0]            hCnt_q, hCnt_d, hInc;
    logic [10:0]            vCnt_q, vCnt_d, vInc, vAtEdge;
    logic                   hSeen_q, hSeen_d;

    logic                   hsEdge, vsEdge;
    logic                   hSat, vSat, satErr, lineErr, frameErr, anyErr;
    logic                   inWin;
    logic [7:0]             goodInc;

    logic [X_POS_W-1:0]     pixelX_q;
    logic [Y_POS_W-1:0]     pixelY_q;
    logic                   visible_q;
    logic [3*COLOR_W-1:0]   rgb_q;
    logic                   newFrame_q;
    logic                   timingErr_q;

    // Edges are judged on stage 1 against its own previous value.
    assign hsEdge = (hs1_q == HS_ON) && (hs2_q != HS_ON);
    assign vsEdge = (vs1_q == VS_ON) && (vs2_q != VS_ON);

    assign hInc    = (hCnt_q == H_MAX) ? hCnt_q : hCnt_q + 12'd1;
    assign hCnt_d  = hsEdge ? 12'd0 : hInc;
    assign vInc    = (vCnt_q == V_MAX) ? vCnt_q : vCnt_q + 11'd1;
    // Line count as seen by a vsync edge: a coincident hsync edge counts first.
    assign vAtEdge = hsEdge ? vInc : vCnt_q;
    assign vCnt_d  = vsEdge ? 11'd0 : vAtEdge;

    // Saturation is flagged only on the step into the ceiling, so it fires once.
    assign hSat     = !hsEdge && (hCnt_q == H_MAX - 12'd1);
    assign vSat     = !vsEdge && hsEdge && (vCnt_q == V_MAX - 11'd1);
    assign satErr   = hSat || vSat;
    assign lineErr  = hsEdge && hSeen_q && (hCnt_q != H_LAST);
    assign frameErr = vsEdge && (state_q != SEARCH) && (vAtEdge != V_LEN);
    assign anyErr   = lineErr || frameErr || satErr;

    // A saturation is a resync: the next hsync edge starts line checking afresh.
    assign hSeen_d  = satErr ? 1'b0 : (hsEdge ? 1'b1 : hSeen_q);

    assign inWin = (hCnt_d >= H_LO) && (hCnt_d < H_HI) &&
                   (vCnt_d >= V_LO) && (vCnt_d < V_HI);

    assign goodInc = goodCnt_q + 8'd1;

    // Input sampling, position counters and the single output register stage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hs1_q       <= ~HS_ON;
            hs2_q       <= ~HS_ON;
            vs1_q       <= ~VS_ON;
            vs2_q       <= ~VS_ON;
            rgb1_q      <= '0;
            hCnt_q      <= '0;
            vCnt_q      <= '0;
            hSeen_q     <= 1'b0;
            pixelX_q    <= '0;
            pixelY_q    <= '0;
            visible_q   <= 1'b0;
            rgb_q       <= '0;
            newFrame_q  <= 1'b0;
            timingErr_q <= 1'b0;
        end else begin
            hs1_q       <= vga_i.hs;
            hs2_q       <= hs1_q;
            vs1_q       <= vga_i.vs;
            vs2_q       <= vs1_q;
            rgb1_q      <= vga_i.rgb;
            hCnt_q      <= hCnt_d;
            vCnt_q      <= vCnt_d;
            hSeen_q     <= hSeen_d;
            pixelX_q    <= inWin ? X_POS_W'(hCnt_d - H_LO) : '0;
            pixelY_q    <= inWin ? Y_POS_W'(vCnt_d - V_LO) : '0;
            visible_q   <= inWin;
            rgb_q       <= inWin ? rgb1_q : '0;
            newFrame_q  <= vsEdge;
            timingErr_q <= anyErr;
        end
    end

    // Lock tracking. Errors at a vsync edge belong to the frame that just ended;
    // an error inside a locked frame marks the rest of that frame as bad.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= SEARCH;
            goodCnt_q  <= '0;
            frameBad_q <= 1'b0;
            locked_q   <= 1'b0;
        end else if (satErr) begin
            state_q    <= SEARCH;
            goodCnt_q  <= '0;
            frameBad_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (vsEdge) begin
                        state_q    <= CHECK;
                        goodCnt_q  <= '0;
                        frameBad_q <= 1'b0;
                    end
                end
                CHECK: begin
                    if (vsEdge) begin
                        frameBad_q <= 1'b0;
                        if (frameBad_q || anyErr) begin
                            goodCnt_q <= '0;
                        end else if (goodInc >= GOOD_N) begin
                            state_q   <= LOCKED;
                            locked_q  <= 1'b1;
                            goodCnt_q <= '0;
                        end else begin
                            goodCnt_q <= goodInc;
                        end
                    end else if (anyErr) begin
                        frameBad_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (anyErr) begin
                        state_q    <= CHECK;
                        locked_q   <= 1'b0;
                        goodCnt_q  <= '0;
                        frameBad_q <= !vsEdge;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_x_o    = pixelX_q;
    assign pixel_y_o    = pixelY_q;
    assign visible_o    = visible_q;
    assign rgb_o        = rgb_q;
    assign new_frame_o  = newFrame_q;
    assign locked_o     = locked_q;
    assign timing_err_o = timingErr_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_decoder
// Drives a scaled-down VGA mode (16 clocks/line, 12 lines/frame) so that
// lock, loss of lock, saturation and reset recovery all fit in a short run.
// Each call of applyStimulus drives one pixel sample; outputs seen at that
// call belong to the sample driven two calls earlier.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_vga_timing_decoder;

    // Scaled-down mode so a frame is a couple of hundred clocks
    localparam int H_TOT = 16;
    localparam int HS_W  = 2;
    localparam int H_ST  = 5;
    localparam int H_VIS = 10;
    localparam int V_TOT = 12;
    localparam int VS_W  = 2;
    localparam int V_ST  = 3;
    localparam int V_VIS = 6;
    localparam int IDLE  = 31;

    logic        clk;
    logic        rst_i;
    logic [9:0]  pixel_x_o;
    logic [9:0]  pixel_y_o;
    logic        visible_o;
    logic [11:0] rgb_o;
    logic        new_frame_o;
    logic        locked_o;
    logic        timing_err_o;

    vga_timing_decoder_if #(.COLOR_W(4)) vgaBus ();

    vga_timing_decoder #(
        .H_TOTAL(H_TOT), .V_TOTAL(V_TOT), .H_START(H_ST), .V_START(V_ST),
        .H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS), .HS_ACTIVE_LOW(1),
        .VS_ACTIVE_LOW(1), .LOCK_FRAMES(2), .X_POS_W(10), .Y_POS_W(10),
        .COLOR_W(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .vga_i(vgaBus),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .visible_o(visible_o),
        .rgb_o(rgb_o), .new_frame_o(new_frame_o), .locked_o(locked_o),
        .timing_err_o(timing_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int histH [2];
    int histV [2];
    int histF [2];
    bit histValid [2];

    int nfSeen [32];
    int lockAtEdge [32];
    int lockPrev [32];
    int errCnt [32];
    int nfTotal;
    int nfAtRelease;
    int lastLocked;
    int lockAtErr;

    // Frame-edge lock state and per-frame error pulses, worked out by hand
    int expLock [18] = '{0,0,1,1,1,0,0,1,1,0,0,0,0,1,1,0,0,1};
    int expErr  [18] = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0,0,0,0,0};

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Observe outputs for the sample from two calls ago, then drive a new one
    task automatic applyStimulus(input logic hs, input logic vs,
                                 input logic [11:0] rgb,
                                 input int h, input int v, input int f);
        int of;
        int oh;
        int ov;
        @(negedge clk);
        of = histValid[1] ? histF[1] : IDLE;
        oh = histH[1];
        ov = histV[1];
        if (new_frame_o) nfTotal++;
        if (timing_err_o) begin
            errCnt[of]++;
            lockAtErr = int'(locked_o);
        end
        if (histValid[1]) begin
            if (oh == 0 && ov == 0) begin
                nfSeen[of]     = int'(new_frame_o);
                lockAtEdge[of] = int'(locked_o);
                lockPrev[of]   = lastLocked;
            end
            if (of == 3) begin
                if (oh == 4 && ov == 3)
                    checkOutput("vis@4,3", visible_o, 0);
                if (oh == 5 && ov == 3) begin
                    checkOutput("vis@5,3", visible_o, 1);
                    checkOutput("x@5,3", pixel_x_o, 0);
                    checkOutput("y@5,3", pixel_y_o, 0);
                    checkOutput("rgb@5,3", rgb_o, 12'hABC);
                end
                if (oh == 14 && ov == 8) begin
                    checkOutput("vis@14,8", visible_o, 1);
                    checkOutput("x@14,8", pixel_x_o, 9);
                    checkOutput("y@14,8", pixel_y_o, 5);
                end
                if (oh == 15 && ov == 8) begin
                    checkOutput("vis@15,8", visible_o, 0);
                    checkOutput("rgb@15,8", rgb_o, 0);
                    checkOutput("x@15,8", pixel_x_o, 0);
                    checkOutput("y@15,8", pixel_y_o, 0);
                end
            end
        end
        lastLocked   = int'(locked_o);
        histH[1]     = histH[0];
        histV[1]     = histV[0];
        histF[1]     = histF[0];
        histValid[1] = histValid[0];
        histH[0]     = h;
        histV[0]     = v;
        histF[0]     = f;
        histValid[0] = 1'b1;
        vgaBus.hs    = hs;
        vgaBus.vs    = vs;
        vgaBus.rgb   = rgb;
    endtask

    // Reset asserted between clock edges, in the middle of a visible line
    task automatic applyMidReset();
        #2;
        rst_i = 1'b0;
        #1;
        checkOutput("rstmid_locked", locked_o, 0);
        checkOutput("rstmid_visible", visible_o, 0);
        checkOutput("rstmid_x", pixel_x_o, 0);
        checkOutput("rstmid_y", pixel_y_o, 0);
        checkOutput("rstmid_rgb", rgb_o, 0);
        checkOutput("rstmid_nf", new_frame_o, 0);
        checkOutput("rstmid_err", timing_err_o, 0);
        repeat (3) @(negedge clk);
        rst_i        = 1'b1;
        histValid[0] = 1'b0;
        histValid[1] = 1'b0;
        nfAtRelease  = nfTotal;
    endtask

    task automatic sendLine(input int v, input int len, input int f, input int rstH);
        logic [11:0] rgb;
        for (int h = 0; h < len; h++) begin
            rgb = (f == 3 && h == H_ST && v == V_ST) ? 12'hABC
                                                     : {4'(h), 4'(v), 4'h7};
            applyStimulus((h < HS_W) ? 1'b0 : 1'b1, (v < VS_W) ? 1'b0 : 1'b1,
                          rgb, h, v, f);
            if (h == rstH) applyMidReset();
        end
    endtask

    task automatic sendFrame(input int f, input int nLines, input int shortLine,
                             input int rstLine);
        for (int v = 0; v < nLines; v++)
            sendLine(v, (v == shortLine) ? H_TOT - 1 : H_TOT, f,
                     (v == rstLine) ? 8 : -1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i      = 1'b0;
        vgaBus.hs  = 1'b1;
        vgaBus.vs  = 1'b1;
        vgaBus.rgb = '0;
        histValid[0] = 1'b0;
        histValid[1] = 1'b0;
        nfTotal     = 0;
        nfAtRelease = 0;
        lastLocked  = 0;
        lockAtErr   = -1;
        for (int i = 0; i < 32; i++) begin
            nfSeen[i]     = -1;
            lockAtEdge[i] = -1;
            lockPrev[i]   = -1;
            errCnt[i]     = 0;
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_locked", locked_o, 0);
        checkOutput("rst_nf", new_frame_o, 0);
        checkOutput("rst_err", timing_err_o, 0);
        checkOutput("rst_visible", visible_o, 0);
        checkOutput("rst_x", pixel_x_o, 0);
        checkOutput("rst_y", pixel_y_o, 0);
        checkOutput("rst_rgb", rgb_o, 0);
        rst_i = 1'b1;
        repeat (4) applyStimulus(1'b1, 1'b1, 12'h000, -1, -1, IDLE);

        // Nominal lock; frame 3 carries the coordinate probes
        for (int f = 0; f < 4; f++) sendFrame(f, V_TOT, -1, -1);

        // One short line inside a locked frame
        sendFrame(4, V_TOT, 5, -1);
        checkOutput("lock_at_line_err", lockAtErr, 0);
        for (int f = 5; f < 8; f++) sendFrame(f, V_TOT, -1, -1);

        // A frame one line short
        sendFrame(8, V_TOT - 1, -1, -1);
        sendFrame(9, V_TOT, -1, -1);
        sendFrame(10, V_TOT, -1, -1);

        // vsync stuck inactive long enough for the line count to saturate
        for (int i = 0; i < 2100; i++) sendLine(5, H_TOT, IDLE, -1);
        for (int f = 11; f < 14; f++) sendFrame(f, V_TOT, -1, -1);

        // Reset in the middle of a visible line of frame 14
        sendFrame(14, V_TOT, -1, 4);
        checkOutput("nf_after_reset", nfTotal - nfAtRelease, 0);
        for (int f = 15; f < 18; f++) sendFrame(f, V_TOT, -1, -1);
        repeat (3) applyStimulus(1'b1, 1'b1, 12'h000, -1, -1, IDLE);

        for (int f = 0; f < 18; f++) begin
            checkOutput($sformatf("nf_f%0d", f), nfSeen[f], 1);
            checkOutput($sformatf("lock_f%0d", f), lockAtEdge[f], expLock[f]);
            checkOutput($sformatf("err_f%0d", f), errCnt[f], expErr[f]);
        end
        checkOutput("lockprev_f2", lockPrev[2], 0);
        checkOutput("lockprev_f9", lockPrev[9], 1);
        checkOutput("lockprev_f13", lockPrev[13], 0);
        checkOutput("lockprev_f17", lockPrev[17], 0);
        checkOutput("err_idle_sat", errCnt[IDLE], 1);
        checkOutput("nf_total", nfTotal, 18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
